// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: compacting instruction fetch queue between the IFU fetch
// path and decode. Each fetch beat of FETCH_INSTS words is trimmed to the
// slots from the start PC up to the first predicted-taken branch. Those slots
// go into a DEPTH-entry circular buffer. Up to ISSUE_WIDTH entries are issued
// per cycle in program order.
// Optional feature: define IFQ_BYPASS_EN to let a beat arriving at an empty
// queue drive issue_* in the same cycle (zero latency).

// One issue lane: zeroes every field when the lane is not valid.
module ifq_issue_lane #(
  parameter int ADDR_W = 32
) (
  input  logic              vld,
  input  logic [31:0]       src_inst,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic              src_pred,
  input  logic              src_err,
  output logic              valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] addr,
  output logic              pred,
  output logic              err
);
  assign valid = vld;
  assign inst  = vld ? src_inst : '0;
  assign addr  = vld ? src_addr : '0;
  assign pred  = vld & src_pred;
  assign err   = vld & src_err;
endmodule

module ifu_fetch_queue #(
  parameter int ADDR_W      = 32,
  parameter int FETCH_INSTS = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  output logic                          fetch_ready_o,
  input  logic [FETCH_INSTS*32-1:0]     fetch_data_i,
  input  logic [ADDR_W-1:0]             fetch_addr_i,
  input  logic [FETCH_INSTS-1:0]        fetch_pred_i,
  input  logic                          fetch_err_i,
  output logic [ISSUE_WIDTH-1:0]        issue_valid_o,
  output logic [ISSUE_WIDTH*32-1:0]     issue_inst_o,
  output logic [ISSUE_WIDTH*ADDR_W-1:0] issue_addr_o,
  output logic [ISSUE_WIDTH-1:0]        issue_pred_o,
  output logic [ISSUE_WIDTH-1:0]        issue_err_o,
  input  logic                          issue_ready_i,
  output logic [$clog2(DEPTH):0]        count_o
);
  localparam int S  = $clog2(FETCH_INSTS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic              pred;
    logic              err;
  } ent_t;

  ent_t              mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic [FETCH_INSTS-1:0][31:0] data_w;
  ent_t [FETCH_INSTS-1:0]       cmp;
  ent_t [FETCH_INSTS-1:0]       wdat;
  logic [FETCH_INSTS-1:0]       wen;
  logic [S-1:0]      s0;
  logic [S:0]        e, n_cmp, kk;
  logic [ADDR_W-1:0] base;
  logic              err_beat, accept;
  logic [CW-1:0]     n_cw, q_vld_n, deq_n, enq_n, skip, src;

  assign data_w        = fetch_data_i;
  assign fetch_ready_o = !rst && (count <= CW'(DEPTH - FETCH_INSTS));
  assign accept        = fetch_valid_i && fetch_ready_o && !flush_i;
  assign count_o       = count;

  // Compact the beat: slots s0..e in order, or a single error entry.
  always_comb begin
    s0       = fetch_addr_i[S+1:2];
    base     = {fetch_addr_i[ADDR_W-1:S+2], (S+2)'(0)};
    err_beat = fetch_err_i || (fetch_addr_i[1:0] != 2'b00);
    e        = (S+1)'(FETCH_INSTS - 1);
    for (int k = FETCH_INSTS - 1; k >= 0; k--)
      if (S'(k) >= s0 && fetch_pred_i[k]) e = (S+1)'(k);
    n_cmp = e - {1'b0, s0} + (S+1)'(1);
    cmp   = '0;
    kk    = '0;
    for (int j = 0; j < FETCH_INSTS; j++) begin
      kk = {1'b0, s0} + (S+1)'(j);
      if (!kk[S]) begin
        cmp[j].inst = data_w[kk[S-1:0]];
        cmp[j].addr = base + ADDR_W'({kk, 2'b00});
        cmp[j].pred = fetch_pred_i[kk[S-1:0]];
      end
    end
    if (err_beat) begin
      n_cmp       = (S+1)'(1);
      cmp         = '0;
      cmp[0].addr = fetch_addr_i;
      cmp[0].err  = 1'b1;
    end
  end

  assign n_cw    = CW'(n_cmp);
  assign q_vld_n = (count < CW'(ISSUE_WIDTH)) ? count : CW'(ISSUE_WIDTH);
  assign deq_n   = issue_ready_i ? q_vld_n : '0;

`ifdef IFQ_BYPASS_EN
  logic          byp_act;
  logic [CW-1:0] byp_n;
  assign byp_act = accept && (count == '0);
  assign byp_n   = (n_cw < CW'(ISSUE_WIDTH)) ? n_cw : CW'(ISSUE_WIDTH);
  // Bypassed instructions consumed this cycle never touch the buffer.
  assign skip    = (byp_act && issue_ready_i) ? byp_n : '0;
`else
  assign skip    = '0;
`endif

  assign enq_n = accept ? (n_cw - skip) : '0;

  // Select which compacted slots land in which write position.
  always_comb begin
    wen  = '0;
    wdat = '0;
    src  = '0;
    for (int j = 0; j < FETCH_INSTS; j++) begin
      src     = CW'(j) + skip;
      wen[j]  = accept && (src < n_cw);
      wdat[j] = cmp[src[S-1:0]];
    end
  end

  // Buffer storage; stale contents are never visible since lanes gate on count.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_INSTS; j++)
      if (wen[j]) mem[wr_ptr + PW'(j)] <= wdat[j];
  end

  // Pointer and occupancy update; flush and reset clear the queue outright.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq_n);
      rd_ptr <= rd_ptr + PW'(deq_n);
      count  <= count + enq_n - deq_n;
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    ent_t lsrc;
    logic lv;
    // Lane i shows entry rd_ptr+i, or compacted slot i on a bypass.
    always_comb begin
      lsrc = mem[rd_ptr + PW'(i)];
      lv   = !rst && (CW'(i) < count);
`ifdef IFQ_BYPASS_EN
      if (byp_act) begin
        lsrc = cmp[i];
        lv   = CW'(i) < byp_n;
      end
`endif
    end
    ifq_issue_lane #(.ADDR_W(ADDR_W)) u_lane (
      .vld      (lv),
      .src_inst (lsrc.inst),
      .src_addr (lsrc.addr),
      .src_pred (lsrc.pred),
      .src_err  (lsrc.err),
      .valid    (issue_valid_o[i]),
      .inst     (issue_inst_o[i*32 +: 32]),
      .addr     (issue_addr_o[i*ADDR_W +: ADDR_W]),
      .pred     (issue_pred_o[i]),
      .err      (issue_err_o[i])
    );
  end
endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction fetch queue between the IFU AXI fetch path and decode. It accepts one fetch beat of FETCH_INSTS naturally aligned 32-bit instructions per handshake and compacts away slots that are invalid because of the start PC or a predicted-taken branch. Compacted instructions are stored in a DEPTH-entry circular buffer and presented to decode up to ISSUE_WIDTH per cycle, in program order. This generalises the fixed two-slot, no-buffering fetch output to any width and depth, and adds branch truncation and error tagging.

## Interface
- ADDR_W, 32, instruction address width
- FETCH_INSTS, 2, instructions per fetch beat; power of 2, ≥2
- ISSUE_WIDTH, 2, max instructions presented per cycle; 1..FETCH_INSTS
- DEPTH, 8, queue entries; power of 2, ≥ FETCH_INSTS
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all queued and incoming instructions
- fetch_valid_i  in  1  fetch beat valid
- fetch_ready_o  out  1  queue can accept a full beat
- fetch_data_i  in  FETCH_INSTS*32  beat; slot k at bits [32k+31:32k]
- fetch_addr_i  in  ADDR_W  fetch PC; selects the first valid slot
- fetch_pred_i  in  FETCH_INSTS  per-slot predicted-taken branch flag
- fetch_err_i  in  1  bus read error for this beat
- issue_valid_o  out  ISSUE_WIDTH  valid mask; always contiguous from bit 0
- issue_inst_o  out  ISSUE_WIDTH*32  instructions
- issue_addr_o  out  ISSUE_WIDTH*ADDR_W  instruction addresses
- issue_pred_o  out  ISSUE_WIDTH  predicted-branch flag per slot
- issue_err_o  out  ISSUE_WIDTH  fetch-error flag per slot
- issue_ready_i  in  1  decode consumes every valid slot this cycle
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Beat accepted when fetch_valid_i && fetch_ready_o && !flush_i.
- Slot index width is S = log2(FETCH_INSTS).
- Start slot is s0 = fetch_addr_i[S+1:2]. Base address is fetch_addr_i with bits [S+1:0] cleared.
- End slot e is the lowest k ≥ s0 with fetch_pred_i[k] = 1; otherwise e = FETCH_INSTS−1.
- Slots s0..e are enqueued in order. Entry: inst = slot data, addr = base + 4k, pred = fetch_pred_i[k], err = 0.
- fetch_err_i = 1: exactly one entry is enqueued, with inst = 32'h0, addr = fetch_addr_i, pred = 0, err = 1. Data and pred are ignored.
- fetch_addr_i[1:0] ≠ 0 is treated as fetch_err_i.
- Dequeue count is popcount(issue_valid_o) when issue_ready_i = 1, else 0.
- issue_valid_o has min(count, ISSUE_WIDTH) low bits set. Outputs come from the read pointer onward.
- Output lanes with valid = 0 drive all-zero inst/addr/pred/err.
- Pointers wrap modulo DEPTH. count_o next = count + enq_n − deq_n.
- fetch_ready_o = !rst && (DEPTH − count_o ≥ FETCH_INSTS). It uses the registered count only, with no same-cycle dequeue credit.
- flush_i: next cycle pointers = 0 and count = 0. A same-cycle enqueue is dropped and a same-cycle dequeue is irrelevant. flush_i has priority over everything except rst.
- Overflow cannot occur by construction. An accepted beat when full is a bench assertion failure.

## Timing
- Reset: count_o = 0, issue_valid_o = 0, all issue data = 0, fetch_ready_o = 0 while rst is high and 1 the cycle after.
- Latency without bypass: beat accepted in cycle N → instructions visible on issue_* in cycle N+1.
- Simultaneous enqueue and dequeue in one cycle is supported at full throughput.
- issue_* outputs are driven from registered state only, with no combinational path from fetch_* to issue_* (except with IFQ_BYPASS_EN).
- issue_ready_i may depend combinationally on issue_valid_o. fetch_ready_o must not depend on issue_ready_i.
- rst asserted mid-operation is identical to flush plus output reset, applied the same cycle.

## Configuration
- IFQ_BYPASS_EN defined, when count_o = 0, !flush_i and a beat is accepted:
  - The first min(n, ISSUE_WIDTH) compacted instructions drive issue_* in the same cycle.
  - If issue_ready_i = 1, those instructions are not written, and only the remainder is enqueued.
  - If issue_ready_i = 0, the whole beat is enqueued.
  - Latency becomes 0 cycles.
- Undefined: no fetch→issue combinational path and latency is 1 cycle.

## Test plan
- Reset then beat addr 0x1000, data {0xB,0xA}, pred 0 → N+1: valid 2'b11, addr {0x1004,0x1000}, insts {B,A}, count 2→0 with ready=1.
- Beat addr 0x1004 (FETCH_INSTS=2) → one entry, addr 0x1004, inst = upper word. Beat addr 0x2000 with pred 2'b01 → one entry at 0x2000, pred=1, slot 1 dropped.
- fetch_err_i=1, addr 0x3000 → one entry err=1, inst 0, addr 0x3000. Addr 0x3002 → same err behaviour.
- issue_ready_i=0, four full beats with DEPTH=8 → count 8, fetch_ready_o=0. A fifth beat is not accepted. One ready cycle → count 6, ready back to 1 the following cycle.
- Count 5 with a beat and flush_i in the same cycle → next cycle count 0, issue_valid_o 0. Pointer wrap: 20 back-to-back beats with continuous ready → in-order addresses, no loss.
- IFQ_BYPASS_EN on, empty queue, ready=1 → issue_valid_o 2'b11 in the acceptance cycle and count stays 0. With ready=0 → count 2.
